// File: rtl/fm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fm_pkg
// Description : Shared widths, limits and exponent-table generator for the
//               FM operator datapath.
// Revision    : 1.0
// ============================================================================
package fm_pkg;

    localparam int ISZ       = 16;
    localparam int ESZ       = 10;
    localparam int OSZ       = 12;
    localparam logic [14:0] ATT_MAX = 15'h7FFF;
    localparam int ENV_SHIFT = 3;
    localparam int MANT_BITS = 11;
    localparam int MAX_SHIFT = 11;

    // Integer square root of a Q48 fraction, result in Q48.
    function automatic logic [63:0] isqrt_q48(input logic [63:0] x);
        logic [127:0] n;
        logic [127:0] cand;
        logic [63:0]  y;
        n = {64'd0, x} << 48;
        y = '0;
        for (int b = 47; b >= 0; b--) begin
            cand = {64'd0, (y | (64'd1 << b))};
            if ((cand * cand) <= n)
                y = y | (64'd1 << b);
        end
        return y;
    endfunction

    // round(2048 * 2^(-(idx+1)/256)); 2^(-k/256) is built from the factors
    // 2^(-2^j/256), each obtained by repeated square roots of one half.
    function automatic logic [MANT_BITS-1:0] mant_val(input int idx);
        logic [8:0]   k;
        logic [63:0]  t;
        logic [127:0] acc;
        k   = 9'(idx + 1);
        t   = 64'd1 << 47;
        acc = 128'd1 << 48;
        if (k[8])
            acc = (acc * {64'd0, t}) >> 48;
        for (int j = 1; j <= 8; j++) begin
            t = isqrt_q48(t);
            if (k[8-j])
                acc = (acc * {64'd0, t}) >> 48;
        end
        return MANT_BITS'((acc + (128'd1 << 36)) >> 37);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exptab.sv
`default_nettype none
// ============================================================================
// Module      : exptab
// Description : 256 x 11 synchronous exponent mantissa ROM.
// Revision    : 1.0
// ============================================================================
module exptab
    import fm_pkg::*;
(
    input  logic                 clk,
    input  logic [7:0]           addr,
    output logic [MANT_BITS-1:0] mant
);

    logic [MANT_BITS-1:0] w_tab [256];

    generate
        for (genvar i = 0; i < 256; i++) begin : g_rom
            localparam logic [MANT_BITS-1:0] c_val = mant_val(i);
            assign w_tab[i] = c_val;
        end
    endgenerate

    always_ff @(posedge clk) begin
        mant <= w_tab[addr];
    end

endmodule
`default_nettype wire

// File: rtl/wave_exp.sv
`default_nettype none
// ============================================================================
// Module      : wave_exp
// Description : Log-to-linear conversion of wavetable output with envelope
//               attenuation; fixed 3-cycle pipeline.
// Revision    : 1.0
// ============================================================================
module wave_exp #(
    parameter int ISZ = fm_pkg::ISZ,
    parameter int ESZ = fm_pkg::ESZ,
    parameter int OSZ = fm_pkg::OSZ
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [ISZ-1:0] wave,
    input  logic [ESZ-1:0] env,
    output logic           out_valid,
    output logic [OSZ-1:0] out
);
    import fm_pkg::*;

    // Stage 0: add envelope, saturate
    logic [15:0] w_sum;
    logic [14:0] w_att;
    logic        r_sign0;
    logic        r_v0;
    logic [14:0] r_att0;

    assign w_sum = 16'(wave[ISZ-2:0]) + (16'(env) << ENV_SHIFT);
    assign w_att = (w_sum > {1'b0, ATT_MAX}) ? ATT_MAX : w_sum[14:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v0    <= 1'b0;
            r_sign0 <= 1'b0;
            r_att0  <= '0;
        end else begin
            r_v0 <= in_valid;
            if (in_valid) begin
                r_sign0 <= wave[ISZ-1];
                r_att0  <= w_att;
            end
        end
    end

    // Stage 1: mantissa lookup; ROM reads every cycle, its address holds with att0
    logic [MANT_BITS-1:0] w_mant;
    logic                 r_sign1;
    logic                 r_v1;
    logic [6:0]           r_shift1;

    exptab u_exptab (
        .clk  (clk),
        .addr (r_att0[7:0]),
        .mant (w_mant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1     <= 1'b0;
            r_sign1  <= 1'b0;
            r_shift1 <= '0;
        end else begin
            r_v1 <= r_v0;
            if (r_v0) begin
                r_sign1  <= r_sign0;
                r_shift1 <= r_att0[14:8];
            end
        end
    end

    // Stage 2: barrel shift and apply sign
    logic [MANT_BITS-1:0] w_mag;
    logic [OSZ-1:0]       w_magx;
    logic [OSZ-1:0]       w_out;

    assign w_mag  = (r_shift1 >= 7'(MAX_SHIFT)) ? '0 : (w_mant >> r_shift1);
    assign w_magx = OSZ'(w_mag);
    assign w_out  = r_sign1 ? (~w_magx + 1'b1) : w_magx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= r_v1;
            if (r_v1)
                out <= w_out;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_exp.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_exp
// Description : Scoreboard testbench for wave_exp.
// Revision    : 1.0
// ============================================================================
module tb_wave_exp;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] wave;
    logic [9:0]  env;
    logic        out_valid;
    logic [11:0] out;

    wave_exp u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .wave      (wave),
        .env       (env),
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t  sb[$];
    int    last_out = 0;
    int    n_tests  = 0;
    int    n_fail   = 0;
    string phase    = "reset";

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s/%s @cyc %0d: got %0d, expected %0d", phase, tag, cyc, obs, exp);
        end
    endtask

    // Independent reference: real-valued exponent, then shift and sign.
    function automatic int ref_out(input logic [15:0] w, input logic [9:0] e);
        int  att, sh, m, mag;
        real x;
        att = int'(w[14:0]) + int'(e) * 8;
        if (att > 32767) att = 32767;
        sh  = att / 256;
        x   = -real'((att % 256) + 1) / 256.0;
        m   = $rtoi(2048.0 * (2.0 ** x) + 0.5);
        mag = (sh > 30) ? 0 : (m / (1 << sh));
        return w[15] ? -mag : mag;
    endfunction

    task automatic monitor();
        int o;
        o = int'($signed(out));
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("out_valid", int'(out_valid), 1);
            check("out", o, sb[0].val);
            last_out = sb[0].val;
            void'(sb.pop_front());
        end else begin
            check("idle_valid", int'(out_valid), 0);
            check("hold", o, last_out);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] w, input logic [9:0] e, input int exp);
        @(negedge clk);
        monitor();
        in_valid = v;
        wave     = w;
        env      = e;
        if (v) sb.push_back('{val: exp, due: cyc + 3});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 16'h0000, 10'h000, 0);
    endtask

    initial begin
        logic [15:0] w;
        logic [9:0]  e;
        logic [7:0]  lo;
        reset = 1'b1; in_valid = 1'b0; wave = '0; env = '0;
        repeat (3) @(negedge clk);
        check("rst_out", int'($signed(out)), 0);
        check("rst_valid", int'(out_valid), 0);
        reset = 1'b0;
        idle(3);

        phase = "directed";
        drive(1'b1, 16'h0000, 10'h000, 2042);
        drive(1'b1, 16'h8000, 10'h000, -2042);
        drive(1'b1, 16'h00FF, 10'h000, 1024);
        drive(1'b1, 16'h0100, 10'h000, 1021);
        drive(1'b1, 16'h8A00, 10'h000, -1);
        drive(1'b1, 16'h8B00, 10'h000, 0);
        drive(1'b1, 16'h0C00, 10'h000, 0);
        drive(1'b1, 16'h8C00, 10'h000, 0);
        drive(1'b1, 16'h0000, 10'h040, 510);
        drive(1'b1, 16'h0000, 10'h058, ref_out(16'h0000, 10'h058));
        drive(1'b1, 16'h7FFF, 10'h3FF, 0);
        drive(1'b1, 16'h0300, 10'h000, 255);
        idle(5);

        phase = "midreset";
        drive(1'b1, 16'h0000, 10'h000, 2042);
        drive(1'b1, 16'h8000, 10'h000, -2042);
        drive(1'b1, 16'h0100, 10'h000, 1021);
        @(negedge clk);
        monitor();
        in_valid = 1'b0;
        reset    = 1'b1;
        sb.delete();
        last_out = 0;
        #1;
        check("async_out", int'($signed(out)), 0);
        check("async_valid", int'(out_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(6);
        drive(1'b1, 16'h8100, 10'h000, -1021);
        idle(4);

        phase = "sweep";
        for (int i = 0; i < 256; i++) begin
            lo = i[7:0];
            w  = {i[0], 4'b0000, lo[3:1], lo};
            e  = 10'($urandom_range(0, 15));
            drive(1'b1, w, e, ref_out(w, e));
        end
        idle(4);

        phase = "gapped";
        drive(1'b1, 16'h0100, 10'h000, 1021);
        drive(1'b0, 16'h0000, 10'h000, 0);
        drive(1'b0, 16'h0000, 10'h000, 0);
        drive(1'b1, 16'h8200, 10'h000, -510);
        drive(1'b0, 16'h0000, 10'h000, 0);
        drive(1'b1, 16'h0080, 10'h000, ref_out(16'h0080, 10'h000));
        idle(6);

        phase = "drain";
        check("pending", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
